// File: rtl/xsram_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : xsram_arbiter_if
//  Description : Request/grant bundle between the X SRAM arbiter, its three
//                requesters (wbuf_send, output_send, host) and the SRAM port.
//  Revision    : 1.0  initial release
// ============================================================================
interface xsram_arbiter_if #(
   parameter int DW = 256
);
   logic          PURGE;

   logic          WB_REQ;
   logic [15:0]   WB_ADDR;
   logic [7:0]    WB_LEN;
   logic          WB_GNT;
   logic          WB_RVALID;

   logic          OS_REQ;
   logic [15:0]   OS_ADDR;
   logic [7:0]    OS_LEN;
   logic [DW-1:0] OS_WDATA;
   logic          OS_GNT;
   logic          OS_WREADY;

   logic          HOST_REQ;
   logic          HOST_WE;
   logic [15:0]   HOST_ADDR;
   logic [DW-1:0] HOST_WDATA;
   logic          HOST_GNT;
   logic          HOST_RVALID;

   logic [15:0]   ADDRX;
   logic          CEBX;
   logic          WEBX;
   logic [DW-1:0] DX;
   logic          BUSY;

   modport slave (
      input  PURGE,
      input  WB_REQ, WB_ADDR, WB_LEN,
      output WB_GNT, WB_RVALID,
      input  OS_REQ, OS_ADDR, OS_LEN, OS_WDATA,
      output OS_GNT, OS_WREADY,
      input  HOST_REQ, HOST_WE, HOST_ADDR, HOST_WDATA,
      output HOST_GNT, HOST_RVALID,
      output ADDRX, CEBX, WEBX, DX, BUSY
   );

   modport master (
      output PURGE,
      output WB_REQ, WB_ADDR, WB_LEN,
      input  WB_GNT, WB_RVALID,
      output OS_REQ, OS_ADDR, OS_LEN, OS_WDATA,
      input  OS_GNT, OS_WREADY,
      output HOST_REQ, HOST_WE, HOST_ADDR, HOST_WDATA,
      input  HOST_GNT, HOST_RVALID,
      input  ADDRX, CEBX, WEBX, DX, BUSY
   );
endinterface
`default_nettype wire

// File: rtl/xsram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : xsram_arbiter
//  Description : Arbitrates the single X SRAM port between host single-beat
//                accesses and round-robin wbuf_send / output_send bursts.
//  Revision    : 1.0  initial release
// ============================================================================
module xsram_arbiter #(
   parameter int DW = 256
) (
   input  wire logic       CLK,
   input  wire logic       RSTL,
   xsram_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOST = 2'd1,
      ST_WB   = 2'd2,
      ST_OS   = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [15:0]   r_addr;
   logic [7:0]    r_cnt;
   logic          r_ptr_os;
   logic          r_host_we;
   logic [DW-1:0] r_host_wdata;
   logic          r_wb_rvalid;
   logic          r_host_rvalid;

   logic          w_grant_host;
   logic          w_grant_wb;
   logic          w_grant_os;
   logic          w_in_burst;
   logic          w_last;

   assign w_in_burst = (r_state == ST_WB) || (r_state == ST_OS);
   assign w_last     = (r_cnt == 8'd0);

   always_ff @(posedge CLK or negedge RSTL) begin
      if (!RSTL) begin
         r_state       <= ST_IDLE;
         r_addr        <= 16'd0;
         r_cnt         <= 8'd0;
         r_ptr_os      <= 1'b0;
         r_host_we     <= 1'b0;
         r_host_wdata  <= '0;
         r_wb_rvalid   <= 1'b0;
         r_host_rvalid <= 1'b0;
      end else if (bus.PURGE) begin
         r_state       <= ST_IDLE;
         r_addr        <= 16'd0;
         r_cnt         <= 8'd0;
         r_ptr_os      <= 1'b0;
         r_host_we     <= 1'b0;
         r_host_wdata  <= '0;
         r_wb_rvalid   <= 1'b0;
         r_host_rvalid <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         // SRAM read latency is one cycle, so valid trails the beat by one
         r_wb_rvalid   <= (r_state == ST_WB);
         r_host_rvalid <= (r_state == ST_HOST) && !r_host_we;
         if (w_grant_host) begin
            r_addr       <= bus.HOST_ADDR;
            r_cnt        <= 8'd0;
            r_host_we    <= bus.HOST_WE;
            r_host_wdata <= bus.HOST_WDATA;
         end else if (w_grant_wb) begin
            r_addr <= bus.WB_ADDR;
            r_cnt  <= bus.WB_LEN;
         end else if (w_grant_os) begin
            r_addr <= bus.OS_ADDR;
            r_cnt  <= bus.OS_LEN;
         end else if (w_in_burst && !w_last) begin
            r_addr <= r_addr + 16'd1;
            r_cnt  <= r_cnt - 8'd1;
         end
         // Completed burst hands priority to the other burst requester
         if (w_in_burst && w_last) begin
            r_ptr_os <= (r_state == ST_WB);
         end
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_grant_host    = 1'b0;
      w_grant_wb      = 1'b0;
      w_grant_os      = 1'b0;
      bus.CEBX        = 1'b1;
      bus.WEBX        = 1'b1;
      bus.ADDRX       = 16'd0;
      bus.DX          = '0;
      bus.WB_GNT      = 1'b0;
      bus.OS_GNT      = 1'b0;
      bus.OS_WREADY   = 1'b0;
      bus.HOST_GNT    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.HOST_REQ) begin
               w_grant_host = 1'b1;
               w_state_nxt  = ST_HOST;
            end else if (bus.WB_REQ && (!bus.OS_REQ || !r_ptr_os)) begin
               w_grant_wb   = 1'b1;
               w_state_nxt  = ST_WB;
            end else if (bus.OS_REQ) begin
               w_grant_os   = 1'b1;
               w_state_nxt  = ST_OS;
            end
         end
         ST_HOST: begin
            w_state_nxt  = ST_IDLE;
            bus.CEBX     = 1'b0;
            bus.WEBX     = ~r_host_we;
            bus.ADDRX    = r_addr;
            bus.DX       = r_host_wdata;
            bus.HOST_GNT = 1'b1;
         end
         ST_WB: begin
            if (w_last) w_state_nxt = ST_IDLE;
            bus.CEBX     = 1'b0;
            bus.ADDRX    = r_addr;
            bus.WB_GNT   = 1'b1;
         end
         ST_OS: begin
            if (w_last) w_state_nxt = ST_IDLE;
            bus.CEBX      = 1'b0;
            bus.WEBX      = 1'b0;
            bus.ADDRX     = r_addr;
            bus.DX        = bus.OS_WDATA;
            bus.OS_GNT    = 1'b1;
            bus.OS_WREADY = 1'b1;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign bus.BUSY        = (r_state != ST_IDLE);
   assign bus.WB_RVALID   = r_wb_rvalid;
   assign bus.HOST_RVALID = r_host_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_xsram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_xsram_arbiter
//  Description : Directed scoreboard bench for xsram_arbiter; expected SRAM
//                beats are queued by the stimulus and popped by a monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_xsram_arbiter;
   localparam int DW = 256;

   logic CLK  = 1'b0;
   logic RSTL = 1'b0;
   int   cyc  = 0;

   xsram_arbiter_if #(.DW(DW)) bus ();
   xsram_arbiter #(.DW(DW)) dut (.CLK(CLK), .RSTL(RSTL), .bus(bus));

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int            cy;
      logic [15:0]   addr;
      logic          webx;
      logic [DW-1:0] d;
      int            kind;   // 0 = WB, 1 = OS, 2 = HOST
      bit            chk_d;
   } beat_t;

   beat_t q[$];
   int n_tests = 0, n_fail = 0;
   int wb_rv_cnt = 0, host_rv_cnt = 0, wready_cnt = 0, busy_cnt = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] pat(input logic [31:0] seed, input int k);
      logic [31:0] w;
      w = seed ^ 32'(k);
      return {8{w}};
   endfunction

   task automatic push(input int cy, input logic [15:0] a, input logic w,
                       input logic [DW-1:0] d, input int kind, input bit cd);
      beat_t b;
      b.cy = cy; b.addr = a; b.webx = w; b.d = d; b.kind = kind; b.chk_d = cd;
      q.push_back(b);
   endtask

   // Monitor: compares every SRAM beat against the queue and checks read latency
   initial begin : monitor
      logic prev_wb, prev_hr;
      beat_t e;
      prev_wb = 1'b0;
      prev_hr = 1'b0;
      forever begin
         @(negedge CLK);
         if (!RSTL) begin
            prev_wb = 1'b0;
            prev_hr = 1'b0;
         end else begin
            chk("wb_rvalid_latency", int'(bus.WB_RVALID), int'(prev_wb));
            chk("host_rvalid_latency", int'(bus.HOST_RVALID), int'(prev_hr));
            if (bus.WB_RVALID)   wb_rv_cnt++;
            if (bus.HOST_RVALID) host_rv_cnt++;
            if (bus.OS_WREADY)   wready_cnt++;
            if (bus.BUSY)        busy_cnt++;
            if (!bus.CEBX) begin
               if (q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL beat_unexpected: got beat at addr %h cycle %0d required none", bus.ADDRX, cyc);
               end else begin
                  e = q.pop_front();
                  chk("beat_cycle", cyc, e.cy);
                  chk("beat_addr", int'(bus.ADDRX), int'(e.addr));
                  chk("beat_webx", int'(bus.WEBX), int'(e.webx));
                  chk("beat_busy", int'(bus.BUSY), 1);
                  if (e.chk_d) chkd("beat_dx", bus.DX, e.d);
                  case (e.kind)
                     0: chk("beat_wb_gnt", int'(bus.WB_GNT), 1);
                     1: chk("beat_os_wready", int'(bus.OS_GNT & bus.OS_WREADY), 1);
                     default: chk("beat_host_gnt", int'(bus.HOST_GNT), 1);
                  endcase
               end
            end
            prev_wb = !bus.CEBX && bus.WB_GNT;
            prev_hr = bus.HOST_GNT && bus.WEBX;
         end
      end
   end

   task automatic wb_req(input logic [15:0] a, input logic [7:0] l);
      logic prev;
      bit   ok;
      ok = 1'b0;
      bus.WB_ADDR = a; bus.WB_LEN = l; bus.WB_REQ = 1'b1;
      prev = bus.WB_GNT;
      for (int i = 0; i < 100; i++) begin
         @(posedge CLK); #1;
         if (bus.WB_GNT && !prev) begin ok = 1'b1; break; end
         prev = bus.WB_GNT;
      end
      bus.WB_REQ = 1'b0;
      if (!ok) begin
         n_tests++; n_fail++;
         $display("FAIL wb_grant_timeout: got no grant required grant");
      end
   endtask

   task automatic os_req(input logic [15:0] a, input logic [7:0] l, input logic [31:0] seed);
      logic prev;
      bit   ok;
      ok = 1'b0;
      bus.OS_ADDR = a; bus.OS_LEN = l; bus.OS_WDATA = pat(seed, 0); bus.OS_REQ = 1'b1;
      prev = bus.OS_GNT;
      for (int i = 0; i < 100; i++) begin
         @(posedge CLK); #1;
         if (bus.OS_GNT && !prev) begin ok = 1'b1; break; end
         prev = bus.OS_GNT;
      end
      bus.OS_REQ = 1'b0;
      if (!ok) begin
         n_tests++; n_fail++;
         $display("FAIL os_grant_timeout: got no grant required grant");
      end else begin
         for (int k = 1; k <= int'(l); k++) begin
            @(posedge CLK); #1;
            bus.OS_WDATA = pat(seed, k);
         end
      end
   endtask

   task automatic host_req(input logic we, input logic [15:0] a, input logic [DW-1:0] d);
      logic prev;
      bit   ok;
      ok = 1'b0;
      bus.HOST_WE = we; bus.HOST_ADDR = a; bus.HOST_WDATA = d; bus.HOST_REQ = 1'b1;
      prev = bus.HOST_GNT;
      for (int i = 0; i < 100; i++) begin
         @(posedge CLK); #1;
         if (bus.HOST_GNT && !prev) begin ok = 1'b1; break; end
         prev = bus.HOST_GNT;
      end
      bus.HOST_REQ = 1'b0;
      if (!ok) begin
         n_tests++; n_fail++;
         $display("FAIL host_grant_timeout: got no grant required grant");
      end
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 200; i++) begin
         @(posedge CLK); #1;
         if (q.size() == 0 && !bus.BUSY) break;
      end
      repeat (2) begin @(posedge CLK); #1; end
      chk(name, q.size(), 0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int c, r0, b0, w0, h0;
      logic [DW-1:0] hw, hr;
      hw = {8{32'hDEAD_0001}};
      hr = {8{32'h1234_5678}};
      bus.PURGE = 1'b0;
      bus.WB_REQ = 1'b0; bus.WB_ADDR = '0; bus.WB_LEN = '0;
      bus.OS_REQ = 1'b0; bus.OS_ADDR = '0; bus.OS_LEN = '0; bus.OS_WDATA = '0;
      bus.HOST_REQ = 1'b0; bus.HOST_WE = 1'b0; bus.HOST_ADDR = '0; bus.HOST_WDATA = '0;

      // Reset values
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_cebx", int'(bus.CEBX), 1);
      chk("rst_webx", int'(bus.WEBX), 1);
      chk("rst_addrx", int'(bus.ADDRX), 0);
      chkd("rst_dx", bus.DX, '0);
      chk("rst_busy", int'(bus.BUSY), 0);
      chk("rst_gnts", int'({bus.WB_GNT, bus.OS_GNT, bus.OS_WREADY, bus.HOST_GNT}), 0);
      chk("rst_rvalids", int'({bus.WB_RVALID, bus.HOST_RVALID}), 0);
      RSTL = 1'b1;

      // WB read burst, 4 beats
      @(posedge CLK); #1;
      c = cyc; r0 = wb_rv_cnt; b0 = busy_cnt;
      for (int k = 0; k < 4; k++) push(c + 1 + k, 16'(16'h0010 + k), 1'b1, '0, 0, 1'b0);
      wb_req(16'h0010, 8'd3);
      drain("t030_drain");
      chk("t030_rvalid_pulses", wb_rv_cnt - r0, 4);
      chk("t030_busy_cycles", busy_cnt - b0, 4);

      // OS write burst wrapping through 0xFFFF
      @(posedge CLK); #1;
      c = cyc; w0 = wready_cnt;
      push(c + 1, 16'hFFFE, 1'b0, pat(32'd31, 0), 1, 1'b1);
      push(c + 2, 16'hFFFF, 1'b0, pat(32'd31, 1), 1, 1'b1);
      push(c + 3, 16'h0000, 1'b0, pat(32'd31, 2), 1, 1'b1);
      os_req(16'hFFFE, 8'd2, 32'd31);
      drain("t031_drain");
      chk("t031_wready_pulses", wready_cnt - w0, 3);

      // Three-way request: host first, then WB, OS, WB again
      @(posedge CLK); #1;
      c = cyc; h0 = host_rv_cnt;
      push(c + 1,  16'h00AA, 1'b0, hw, 2, 1'b1);
      push(c + 3,  16'h0100, 1'b1, '0, 0, 1'b0);
      push(c + 4,  16'h0101, 1'b1, '0, 0, 1'b0);
      push(c + 6,  16'h0200, 1'b0, pat(32'd32, 0), 1, 1'b1);
      push(c + 7,  16'h0201, 1'b0, pat(32'd32, 1), 1, 1'b1);
      push(c + 9,  16'h0300, 1'b1, '0, 0, 1'b0);
      push(c + 10, 16'h0301, 1'b1, '0, 0, 1'b0);
      fork
         host_req(1'b1, 16'h00AA, hw);
         begin wb_req(16'h0100, 8'd1); wb_req(16'h0300, 8'd1); end
         os_req(16'h0200, 8'd1, 32'd32);
      join
      drain("t032_drain");
      chk("t032_host_write_no_rvalid", host_rv_cnt - h0, 0);

      // Host read raised mid WB burst waits for burst end
      @(posedge CLK); #1;
      c = cyc; h0 = host_rv_cnt;
      for (int k = 0; k < 6; k++) push(c + 1 + k, 16'(16'h0400 + k), 1'b1, '0, 0, 1'b0);
      push(c + 8, 16'h1234, 1'b1, hr, 2, 1'b1);
      fork
         wb_req(16'h0400, 8'd5);
         begin repeat (2) begin @(posedge CLK); #1; end host_req(1'b0, 16'h1234, hr); end
      join
      drain("t033_drain");
      chk("t033_host_rvalid_pulses", host_rv_cnt - h0, 1);

      // PURGE at beat 2 of an OS burst; pointer returns to WB
      @(posedge CLK); #1;
      c = cyc; w0 = wready_cnt;
      for (int k = 0; k < 3; k++) push(c + 1 + k, 16'(16'h0500 + k), 1'b0, pat(32'd34, k), 1, 1'b1);
      fork
         os_req(16'h0500, 8'd7, 32'd34);
         begin
            repeat (3) @(posedge CLK);
            #1; bus.PURGE = 1'b1;
            @(posedge CLK); #1;
            chk("t034_busy_after_purge", int'(bus.BUSY), 0);
            chk("t034_cebx_after_purge", int'(bus.CEBX), 1);
            bus.PURGE = 1'b0;
         end
      join
      drain("t034_drain");
      chk("t034_wready_pulses", wready_cnt - w0, 3);
      @(posedge CLK); #1;
      c = cyc;
      push(c + 1, 16'h0600, 1'b1, '0, 0, 1'b0);
      push(c + 3, 16'h0700, 1'b0, pat(32'd35, 0), 1, 1'b1);
      fork
         wb_req(16'h0600, 8'd0);
         os_req(16'h0700, 8'd0, 32'd35);
      join
      drain("t034_post_drain");

      // Asynchronous reset in the middle of a WB burst
      @(posedge CLK); #1;
      c = cyc;
      push(c + 1, 16'h0800, 1'b1, '0, 0, 1'b0);
      push(c + 2, 16'h0801, 1'b1, '0, 0, 1'b0);
      fork
         wb_req(16'h0800, 8'd7);
         begin
            repeat (3) @(posedge CLK);
            #1; RSTL = 1'b0;
            #1;
            chk("t035_cebx", int'(bus.CEBX), 1);
            chk("t035_webx", int'(bus.WEBX), 1);
            chk("t035_addrx", int'(bus.ADDRX), 0);
            chk("t035_busy", int'(bus.BUSY), 0);
            chk("t035_wb_gnt", int'(bus.WB_GNT), 0);
            chk("t035_wb_rvalid", int'(bus.WB_RVALID), 0);
         end
      join
      r0 = wb_rv_cnt;
      repeat (2) @(posedge CLK);
      #1; RSTL = 1'b1;
      repeat (6) @(posedge CLK);
      #1;
      chk("t035_queue_empty", q.size(), 0);
      chk("t035_no_rvalid_after_release", wb_rv_cnt - r0, 0);
      chk("t035_idle_after_release", int'(bus.BUSY), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
